// File: rtl/mcdf_pkg.sv
// Shared constants, types and helpers for the MCDF codebase slice:
// command codes, register map, channel count, FIFO depth and arbiter helpers.
package mcdf_pkg;

    localparam logic [1:0] CMD_IDLE  = 2'b00;
    localparam logic [1:0] CMD_WRITE = 2'b10;
    localparam logic [1:0] CMD_READ  = 2'b01;

    localparam logic [7:0] SLV0_RW_ADDR = 8'h00;
    localparam logic [7:0] SLV1_RW_ADDR = 8'h04;
    localparam logic [7:0] SLV2_RW_ADDR = 8'h08;
    localparam logic [7:0] SLV0_R_ADDR  = 8'h10;
    localparam logic [7:0] SLV1_R_ADDR  = 8'h14;
    localparam logic [7:0] SLV2_R_ADDR  = 8'h18;

    localparam int CH_NUM     = 3;
    localparam int FIFO_DEPTH = 64;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } arb_state_e;

    // Packet length code to word count; codes 3..7 all mean 32 words.
    function automatic logic [5:0] pkglen_decode(input logic [2:0] code);
        logic [5:0] len;
        case (code)
            3'd0:    len = 6'd4;
            3'd1:    len = 6'd8;
            3'd2:    len = 6'd16;
            default: len = 6'd32;
        endcase
        return len;
    endfunction

    // Next channel in round-robin order, wrapping 2 -> 0.
    function automatic logic [1:0] rr_next(input logic [1:0] ch);
        logic [1:0] nxt;
        case (ch)
            2'd0:    nxt = 2'd1;
            2'd1:    nxt = 2'd2;
            default: nxt = 2'd0;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/prio_rr_select.sv
// Combinational winner selection: lowest priority value wins, ties are
// resolved round-robin starting at the channel after the last grant.
module prio_rr_select
    import mcdf_pkg::*;
(
    input  logic [CH_NUM-1:0]      i_eligible,
    input  logic [CH_NUM-1:0][1:0] i_prio,
    input  logic [1:0]             i_last_grant,
    output logic [1:0]             o_winner,
    output logic                   o_found
);

    logic [1:0] w_best_prio;
    logic [1:0] w_ch;

    // Lowest priority value among the eligible channels.
    always_comb begin
        w_best_prio = 2'd3;
        for (int i = 0; i < CH_NUM; i++) begin
            if (i_eligible[i] && (i_prio[i] < w_best_prio)) begin
                w_best_prio = i_prio[i];
            end else begin
                w_best_prio = w_best_prio;
            end
        end
    end

    // First eligible channel at the best priority, scanning after last grant.
    always_comb begin
        o_winner = 2'd0;
        o_found  = 1'b0;
        w_ch     = rr_next(i_last_grant);
        for (int k = 0; k < CH_NUM; k++) begin
            if (!o_found && i_eligible[w_ch] && (i_prio[w_ch] == w_best_prio)) begin
                o_found  = 1'b1;
                o_winner = w_ch;
            end else begin
                o_found  = o_found;
            end
            w_ch = rr_next(w_ch);
        end
    end

endmodule

// File: rtl/mcdf_arbiter.sv
// MCDF arbiter: grants the formatter to one slave FIFO channel per packet and
// streams exactly one packet of that channel's length with valid/ready.
module mcdf_arbiter
    import mcdf_pkg::*;
#(
    parameter int DW   = 32,
    parameter int CNTW = $clog2(FIFO_DEPTH) + 1
) (
    input  logic            clk_i,
    input  logic            rstn_i,
    input  logic            slv0_en_i,
    input  logic            slv1_en_i,
    input  logic            slv2_en_i,
    input  logic [1:0]      slv0_prio_i,
    input  logic [1:0]      slv1_prio_i,
    input  logic [1:0]      slv2_prio_i,
    input  logic [2:0]      slv0_pkglen_i,
    input  logic [2:0]      slv1_pkglen_i,
    input  logic [2:0]      slv2_pkglen_i,
    input  logic [CNTW-1:0] slv0_count_i,
    input  logic [CNTW-1:0] slv1_count_i,
    input  logic [CNTW-1:0] slv2_count_i,
    input  logic [DW-1:0]   slv0_data_i,
    input  logic [DW-1:0]   slv1_data_i,
    input  logic [DW-1:0]   slv2_data_i,
    output logic            slv0_pop_o,
    output logic            slv1_pop_o,
    output logic            slv2_pop_o,
    output logic            fmt_valid_o,
    input  logic            fmt_ready_i,
    output logic [DW-1:0]   fmt_data_o,
    output logic [1:0]      fmt_id_o,
    output logic [5:0]      fmt_len_o,
    output logic            fmt_sop_o,
    output logic            fmt_eop_o,
    output logic            arb_busy_o
);

    logic [CH_NUM-1:0]           w_en;
    logic [CH_NUM-1:0][1:0]      w_prio;
    logic [CH_NUM-1:0][2:0]      w_code;
    logic [CH_NUM-1:0][CNTW-1:0] w_count;
    logic [CH_NUM-1:0][DW-1:0]   w_data;
    logic [CH_NUM-1:0][5:0]      w_len;
    logic [CH_NUM-1:0]           w_eligible;
    logic [1:0]                  w_winner;
    logic                        w_found;
    logic                        w_accept;

    arb_state_e r_state;
    logic [1:0] r_id;
    logic [5:0] r_len;
    logic [5:0] r_cnt;
    logic [1:0] r_last_grant;
    logic       r_valid;
    logic       r_sop;
    logic       r_eop;
    logic       r_busy;

    assign w_en    = {slv2_en_i, slv1_en_i, slv0_en_i};
    assign w_prio  = {slv2_prio_i, slv1_prio_i, slv0_prio_i};
    assign w_code  = {slv2_pkglen_i, slv1_pkglen_i, slv0_pkglen_i};
    assign w_count = {slv2_count_i, slv1_count_i, slv0_count_i};
    assign w_data  = {slv2_data_i, slv1_data_i, slv0_data_i};

    // A channel may only be granted once a whole packet is already buffered,
    // so the stream can never underflow its FIFO.
    always_comb begin
        for (int i = 0; i < CH_NUM; i++) begin
            w_len[i]      = pkglen_decode(w_code[i]);
            w_eligible[i] = w_en[i] && (w_count[i] >= CNTW'(w_len[i]));
        end
    end

    prio_rr_select u_select (
        .i_eligible   (w_eligible),
        .i_prio       (w_prio),
        .i_last_grant (r_last_grant),
        .o_winner     (w_winner),
        .o_found      (w_found)
    );

    assign w_accept = r_valid && fmt_ready_i;

    // Packet FSM: grant and latch in IDLE, count accepted beats in SEND.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state      <= ST_IDLE;
            r_id         <= 2'd0;
            r_len        <= 6'd0;
            r_cnt        <= 6'd0;
            r_last_grant <= 2'd2;
            r_valid      <= 1'b0;
            r_sop        <= 1'b0;
            r_eop        <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_state      <= ST_SEND;
                        r_id         <= w_winner;
                        r_len        <= w_len[w_winner];
                        r_cnt        <= 6'd0;
                        r_last_grant <= w_winner;
                        r_valid      <= 1'b1;
                        r_sop        <= 1'b1;
                        r_eop        <= 1'b0;
                        r_busy       <= 1'b1;
                    end else begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_SEND: begin
                    if (w_accept) begin
                        if (r_cnt == (r_len - 6'd1)) begin
                            r_state <= ST_IDLE;
                            r_cnt   <= 6'd0;
                            r_valid <= 1'b0;
                            r_sop   <= 1'b0;
                            r_eop   <= 1'b0;
                            r_busy  <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 6'd1;
                            r_sop <= 1'b0;
                            r_eop <= ((r_cnt + 6'd2) == r_len);
                        end
                    end else begin
                        r_cnt <= r_cnt;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= 6'd0;
                    r_valid <= 1'b0;
                    r_sop   <= 1'b0;
                    r_eop   <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign fmt_valid_o = r_valid;
    assign fmt_sop_o   = r_sop;
    assign fmt_eop_o   = r_eop;
    assign fmt_id_o    = r_id;
    assign fmt_len_o   = r_len;
    assign arb_busy_o  = r_busy;
    // Data is forced to zero outside a packet so reset shows an all-zero port.
    assign fmt_data_o  = r_valid ? w_data[r_id] : {DW{1'b0}};

    assign slv0_pop_o = w_accept && (r_id == 2'd0);
    assign slv1_pop_o = w_accept && (r_id == 2'd1);
    assign slv2_pop_o = w_accept && (r_id == 2'd2);

endmodule

// File: tb/tb_mcdf_arbiter.sv
// Self-checking bench for mcdf_arbiter: emulated show-ahead FIFOs, a
// transaction-level reference model, directed scenarios and a random phase.
module tb_mcdf_arbiter;

    logic        clk_i = 1'b0;
    logic        rstn_i;
    logic [2:0]  en;
    logic [1:0]  prio   [3];
    logic [2:0]  pkglen [3];
    logic [6:0]  cnt    [3];
    logic [31:0] dat    [3];
    logic [2:0]  pops;
    logic        ready;
    logic        fmt_valid_o;
    logic [31:0] fmt_data_o;
    logic [1:0]  fmt_id_o;
    logic [5:0]  fmt_len_o;
    logic        fmt_sop_o;
    logic        fmt_eop_o;
    logic        arb_busy_o;

    always #5 clk_i = ~clk_i;

    mcdf_arbiter #(.DW(32), .CNTW(7)) dut (
        .clk_i         (clk_i),
        .rstn_i        (rstn_i),
        .slv0_en_i     (en[0]),
        .slv1_en_i     (en[1]),
        .slv2_en_i     (en[2]),
        .slv0_prio_i   (prio[0]),
        .slv1_prio_i   (prio[1]),
        .slv2_prio_i   (prio[2]),
        .slv0_pkglen_i (pkglen[0]),
        .slv1_pkglen_i (pkglen[1]),
        .slv2_pkglen_i (pkglen[2]),
        .slv0_count_i  (cnt[0]),
        .slv1_count_i  (cnt[1]),
        .slv2_count_i  (cnt[2]),
        .slv0_data_i   (dat[0]),
        .slv1_data_i   (dat[1]),
        .slv2_data_i   (dat[2]),
        .slv0_pop_o    (pops[0]),
        .slv1_pop_o    (pops[1]),
        .slv2_pop_o    (pops[2]),
        .fmt_valid_o   (fmt_valid_o),
        .fmt_ready_i   (ready),
        .fmt_data_o    (fmt_data_o),
        .fmt_id_o      (fmt_id_o),
        .fmt_len_o     (fmt_len_o),
        .fmt_sop_o     (fmt_sop_o),
        .fmt_eop_o     (fmt_eop_o),
        .arb_busy_o    (arb_busy_o)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model: one packet in flight or none.
    bit m_busy = 1'b0;
    int m_ch   = 0;
    int m_len  = 0;
    int m_beat = 0;
    int m_last = 2;

    // Observed DUT events.
    int grants[$];
    int sop_cycs[$];
    int gaps[$];
    int last_eop = -1;
    int beats    = 0;
    int pop_cnt[3];

    logic [31:0] q0[$], q1[$], q2[$];

    function automatic int qsize(input int c);
        case (c)
            0:       return q0.size();
            1:       return q1.size();
            default: return q2.size();
        endcase
    endfunction

    function automatic logic [31:0] qhead(input int c);
        case (c)
            0:       return q0[0];
            1:       return q1[0];
            default: return q2[0];
        endcase
    endfunction

    function automatic void qpop(input int c);
        case (c)
            0:       void'(q0.pop_front());
            1:       void'(q1.pop_front());
            default: void'(q2.pop_front());
        endcase
    endfunction

    function automatic void fill(input int c, input int n);
        for (int i = 0; i < n; i++) begin
            if (qsize(c) < 64) begin
                case (c)
                    0:       q0.push_back($urandom);
                    1:       q1.push_back($urandom);
                    default: q2.push_back($urandom);
                endcase
            end
        end
    endfunction

    function automatic void qclear();
        q0.delete();
        q1.delete();
        q2.delete();
    endfunction

    function automatic void clear_rec();
        grants.delete();
        sop_cycs.delete();
        gaps.delete();
        last_eop = -1;
        beats    = 0;
        for (int c = 0; c < 3; c++) pop_cnt[c] = 0;
    endfunction

    function automatic int dec_len(input logic [2:0] code);
        return (code < 3'd3) ? (4 << code) : 32;
    endfunction

    // Winner by the selection rule: best priority first, then rotation from last grant.
    function automatic int pick();
        for (int p = 0; p < 4; p++) begin
            for (int off = 1; off <= 3; off++) begin
                int c;
                c = (m_last + off) % 3;
                if (en[c] && (qsize(c) >= dec_len(pkglen[c])) && (prio[c] == p)) return c;
            end
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive FIFO view, check outputs vs model, advance model at posedge.
    task automatic cycle();
        logic [2:0] e_pop;
        int nxt;
        for (int c = 0; c < 3; c++) begin
            cnt[c] = 7'(qsize(c));
            dat[c] = (qsize(c) > 0) ? qhead(c) : (32'hBAD0_0000 + 32'(c));
        end
        #1;
        e_pop = (m_busy && ready) ? (3'b001 << m_ch) : 3'b000;
        chk("valid", fmt_valid_o, m_busy);
        chk("busy", arb_busy_o, m_busy);
        chk("sop", fmt_sop_o, m_busy && (m_beat == 0));
        chk("eop", fmt_eop_o, m_busy && (m_beat == m_len - 1));
        chk("pop", pops, e_pop);
        chk("data", fmt_data_o, m_busy ? qhead(m_ch) : 32'h0);
        if (m_busy) begin
            chk("id", fmt_id_o, m_ch);
            chk("len", fmt_len_o, m_len);
        end
        if (fmt_valid_o && ready) begin
            beats++;
            if (fmt_sop_o) begin
                grants.push_back(int'(fmt_id_o));
                sop_cycs.push_back(cyc);
                if (last_eop >= 0) gaps.push_back(cyc - last_eop);
            end
            if (fmt_eop_o) last_eop = cyc;
        end
        for (int c = 0; c < 3; c++) if (pops[c]) pop_cnt[c]++;
        nxt = m_busy ? -1 : pick();
        @(posedge clk_i);
        if (m_busy) begin
            if (ready) begin
                qpop(m_ch);
                m_beat++;
                if (m_beat == m_len) m_busy = 1'b0;
            end
        end else if (nxt >= 0) begin
            m_busy = 1'b1;
            m_ch   = nxt;
            m_len  = dec_len(pkglen[nxt]);
            m_beat = 0;
            m_last = nxt;
        end
        cyc++;
        @(negedge clk_i);
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_valid"}, fmt_valid_o, 1'b0);
        chk({tag, "_busy"}, arb_busy_o, 1'b0);
        chk({tag, "_sop"}, fmt_sop_o, 1'b0);
        chk({tag, "_eop"}, fmt_eop_o, 1'b0);
        chk({tag, "_pops"}, pops, 3'b000);
        chk({tag, "_id"}, fmt_id_o, 2'd0);
        chk({tag, "_len"}, fmt_len_o, 6'd0);
        chk({tag, "_data"}, fmt_data_o, 32'h0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k;
        rstn_i = 1'b0;
        en     = 3'b000;
        ready  = 1'b0;
        for (int c = 0; c < 3; c++) begin
            prio[c]   = 2'd0;
            pkglen[c] = 3'd0;
            cnt[c]    = 7'd0;
            dat[c]    = 32'h1234_5678;
        end
        clear_rec();
        repeat (3) @(negedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        rstn_i = 1'b1;

        // Single channel, 4-word packet.
        en = 3'b001; ready = 1'b1; fill(0, 4); clear_rec();
        k = cyc;
        repeat (8) cycle();
        chk("t1_grants", grants.size(), 1);
        chk("t1_sop_latency", (sop_cycs.size() > 0) ? sop_cycs[0] : -1, k + 1);
        chk("t1_id", (grants.size() > 0) ? grants[0] : 99, 0);
        chk("t1_pops", pop_cnt[0], 4);
        chk("t1_beats", beats, 4);
        chk("t1_idle", arb_busy_o, 1'b0);

        // Priority beats rotation; one-cycle gap between packets.
        qclear(); en = 3'b110; prio[1] = 2'd0; prio[2] = 2'd3;
        fill(1, 4); fill(2, 4); clear_rec();
        repeat (16) cycle();
        chk("t2_grants", grants.size(), 2);
        chk("t2_first", (grants.size() > 0) ? grants[0] : 99, 1);
        chk("t2_second", (grants.size() > 1) ? grants[1] : 99, 2);
        chk("t2_gap", (gaps.size() > 0) ? gaps[0] : -1, 2);

        // Round-robin among equal priorities with full FIFOs.
        qclear(); en = 3'b111;
        for (int c = 0; c < 3; c++) begin prio[c] = 2'd1; pkglen[c] = 3'd1; fill(c, 64); end
        clear_rec();
        k = 0;
        while (grants.size() < 4 && k < 60) begin cycle(); k++; end
        en = 3'b000;
        repeat (12) cycle();
        chk("t3_grants", grants.size(), 4);
        for (int i = 0; i < 4; i++)
            chk("t3_order", (grants.size() > i) ? grants[i] : 99, i % 3);
        for (int i = 0; i < 3; i++)
            chk("t3_gap", (gaps.size() > i) ? gaps[i] : -1, 2);
        chk("t3_beats", beats, 32);

        // Backpressure with ready pattern 1,0,0,1.
        qclear(); en = 3'b001; prio[0] = 2'd0; pkglen[0] = 3'd2; fill(0, 16); clear_rec();
        for (int i = 0; i < 80; i++) begin
            ready = ((i % 4) == 0) || ((i % 4) == 3);
            cycle();
        end
        ready = 1'b1;
        chk("t4_beats", beats, 16);
        chk("t4_pops", pop_cnt[0], 16);
        chk("t4_grants", grants.size(), 1);

        // Threshold: count = len-1 not eligible, count = len eligible; config changes ignored.
        qclear(); en = 3'b010; pkglen[1] = 3'd1; fill(1, 7); clear_rec();
        repeat (4) cycle();
        chk("t5_no_grant", grants.size(), 0);
        chk("t5_not_busy", arb_busy_o, 1'b0);
        fill(1, 1);
        repeat (3) cycle();
        pkglen[1] = 3'd3; en = 3'b000;
        repeat (12) cycle();
        chk("t5_grants", grants.size(), 1);
        chk("t5_beats", beats, 8);
        chk("t5_pops", pop_cnt[1], 8);

        // Reset mid-packet at beat 5 of 16.
        qclear(); en = 3'b001; pkglen[0] = 3'd2; fill(0, 16); clear_rec();
        repeat (5) cycle();
        chk("t6_beats_before", beats, 4);
        rstn_i = 1'b0;
        #1;
        chk_all_zero("midrst");
        m_busy = 1'b0; m_last = 2;
        @(negedge clk_i);
        rstn_i = 1'b1;
        for (int c = 0; c < 3; c++) begin prio[c] = 2'd0; pkglen[c] = 3'd0; end
        fill(1, 4); fill(2, 4); en = 3'b111; clear_rec();
        repeat (6) cycle();
        chk("t6_first_after_rst", (grants.size() > 0) ? grants[0] : 99, 0);
        en = 3'b000;
        repeat (40) cycle();

        // Random phase.
        for (int i = 0; i < 800; i++) begin
            ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 7) == 0) begin
                en = 3'($urandom_range(0, 7));
                for (int c = 0; c < 3; c++) begin
                    prio[c]   = 2'($urandom_range(0, 3));
                    pkglen[c] = 3'($urandom_range(0, 7));
                end
            end
            fill($urandom_range(0, 2), $urandom_range(0, 2));
            cycle();
        end
        en = 3'b000; ready = 1'b1;
        repeat (40) cycle();
        chk("final_idle", arb_busy_o, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/mcdf_arbiter.md
# mcdf_arbiter

- Shares the single formatter output between the three slave FIFO channels.
- Grants one channel per packet by priority, with round-robin among equal priorities.
- Streams exactly one packet of that channel's configured length to the formatter with a valid/ready handshake, popping the FIFO one word per accepted beat.
- Takes enable, priority and packet length from the control register block; takes fill levels and data from the slave FIFOs.

## Interface
Parameters:
- DW, 32, data word width
- CNTW, 7, FIFO fill-count width (depth 64, count 0..64)

Ports:
- clk_i  in  1  clock
- rstn_i  in  1  reset, asynchronous, active-low
- slvN_en_i (N=0..2)  in  1  channel enable
- slvN_prio_i  in  2  priority, 0 highest
- slvN_pkglen_i  in  3  packet length code
- slvN_count_i  in  CNTW  words currently stored in FIFO N
- slvN_data_i  in  DW  FIFO N head word (show-ahead, valid whenever count>0)
- slvN_pop_o  out  1  pop FIFO N head
- fmt_valid_o  out  1  beat valid
- fmt_ready_i  in  1  formatter accepts beat
- fmt_data_o  out  DW  beat data
- fmt_id_o  out  2  granted channel id
- fmt_len_o  out  6  packet length in words
- fmt_sop_o / fmt_eop_o  out  1 each  first / last beat of packet
- arb_busy_o  out  1  packet in progress

## Operation
- Packet length decode: code 0→4, 1→8, 2→16, 3–7→32 words.
- A channel is eligible when en=1 and count ≥ decoded length, evaluated on inputs in the current cycle.
- FSM states:
  - IDLE: if any channel is eligible, select the winner; latch id, decoded length and beat counter=0; go to SEND. Otherwise stay in IDLE.
  - SEND: fmt_valid_o=1. On each beat where valid&&ready, pulse pop for the granted channel and increment the counter. The beat with counter==len-1 is eop; that beat returns the FSM to IDLE.
- Selection rule: lowest prio value wins. Ties are broken round-robin, starting at the channel after last_grant (modulo 3). last_grant updates on every grant.
- Output mux: fmt_data_o=slv[id]_data_i (combinational mux); fmt_id_o and fmt_len_o are held for the whole packet.
- fmt_sop_o=1 on counter==0; fmt_eop_o=1 on counter==len-1. Both are qualified by SEND.
- Pops go only to the granted channel. At most one pop is high per cycle. pop=fmt_valid_o&&fmt_ready_i.
- Priority, length or enable changes during SEND do not affect the packet in flight. Disabling the channel mid-packet still completes the packet.
- Eligibility guarantees enough data, so the arbiter never underflows a FIFO. Stall (ready=0) holds all outputs and the counter.

## Timing
- Reset values: state=IDLE, last_grant=2 (so channel 0 wins the first tie), counter=0. All outputs 0: fmt_valid_o, pops, sop, eop, id, len, data, busy.
- Reset asserted mid-packet aborts immediately. The remaining words stay in the FIFO, and no partial eop is emitted.
- Grant latency: eligible in cycle n (state IDLE) → fmt_valid_o=1 with sop in cycle n+1.
- Throughput: one word per cycle while ready=1. A packet of L words with no stalls occupies SEND for L cycles.
- Inter-packet gap: the eop handshake in cycle m is followed by IDLE in m+1, and the next sop can appear at m+2 (one bubble, fixed).
- arb_busy_o=1 exactly while in SEND.
- Boundaries:
  - count exactly equal to length is eligible; count=len-1 is not.
  - count=64 (full) is eligible.
  - Simultaneous eligibility of all three channels at equal priority gives the grant order 0,1,2,0…

## Structure
- Shared package mcdf_pkg holds:
  - READ/WRITE command codes and the register address constants
  - CH_NUM=3
  - the pkglen decode function
  - the arbiter state enum
  - FIFO depth 64
- One sub-module: prio_rr_select. It is combinational and takes eligible[2:0], the three prios and last_grant; it returns the winner id and a found flag. The top level owns the FSM, counter, latching and muxes.

## Test plan
- Ch0 only: en=1, code 0, count=4, ready=1. Expect sop at n+1, then 4 beats id=0 len=4, eop on the 4th beat, exactly 4 pop0 pulses, then IDLE.
- Priority: ch1 prio 0, ch2 prio 3, both eligible → ch1 packet first. Ch2 sop appears 2 cycles after ch1's eop.
- Round-robin: all prio 1, code 1, counts 64, ready=1 → grant order 0,1,2,0. Each packet is 8 beats with a one-cycle gap.
- Backpressure: code 2, ready toggled 1,0,0,1… → 16 accepted beats. Data, counter and sop/eop hold during ready=0. Pops occur only on accepted beats.
- Threshold and config change: count=7 with code 1 → no grant; count=8 → grant. Changing pkglen to 3 and en to 0 during SEND → packet still 8 beats.
- Reset mid-packet: rstn_i=0 at beat 5 of 16 → all outputs 0 immediately. After release, state is IDLE and last_grant=2.
